// File: rtl/benes_route_sequencer_pkg.sv
// Shared types and sizing for the Benes route sequencer and its context table.
// SWITCH_NUM / STAGE_NUM mirror the FHE ALU interconnect geometry (8-port Benes).
package benes_route_sequencer_pkg;

    localparam int SWITCH_NUM = 4;
    localparam int STAGE_NUM  = 5;
    localparam int CTX_DEPTH  = 16;
    localparam int CTX_AW     = $clog2(CTX_DEPTH);
    localparam int STAGE_AW   = $clog2(STAGE_NUM);
    localparam int INTC_LAT   = 3;
    localparam int LEN_W      = 8;

    // One switch-bit row per stage; bit = 1 means cross.
    typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] sel_t;

    typedef struct packed {
        sel_t module_sel;
        sel_t slot_sel;
    } benes_ctx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE
    } route_seq_state_e;

    // Even parity of one stored row.
    function automatic logic row_parity(input logic [SWITCH_NUM-1:0] row);
        return ^row;
    endfunction

endpackage

// File: rtl/benes_route_sequencer_ctx_table.sv
// Permutation context storage: row write port, whole-context read, per-context valid bits.
// BENES_CTX_PARITY_EN adds one even-parity bit per row and a whole-context parity check.
module benes_ctx_table
    import benes_route_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [CTX_AW-1:0]     wr_ctx,
    input  logic                  wr_net,
    input  logic [STAGE_AW-1:0]   wr_stage,
    input  logic [SWITCH_NUM-1:0] wr_data,
    input  logic                  commit,
    input  logic [CTX_AW-1:0]     chk_ctx,
    output logic                  chk_valid,
    input  logic [CTX_AW-1:0]     rd_ctx,
    output benes_ctx_t            rd_data,
    output logic                  rd_parity_ok
);

    logic [SWITCH_NUM-1:0] r2m_mem [CTX_DEPTH][STAGE_NUM];
    logic [SWITCH_NUM-1:0] m2r_mem [CTX_DEPTH][STAGE_NUM];
    logic [CTX_DEPTH-1:0]  valid;

    // Row storage; the valid bits guard every read, so the array carries no reset.
    // NOTE: storage arrays are left unreset on purpose; resetting them adds a wide reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_net) r2m_mem[wr_ctx][wr_stage] <= wr_data;
            else         m2r_mem[wr_ctx][wr_stage] <= wr_data;
        end
    end

    // Valid bits: a row write invalidates, a commit in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (wr_en)  valid[wr_ctx] <= 1'b0;
            if (commit) valid[wr_ctx] <= 1'b1;
        end
    end

    assign chk_valid = valid[chk_ctx];

    // Full-context read for the LOAD copy.
    always_comb begin
        rd_data = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            rd_data.module_sel[s] = r2m_mem[rd_ctx][s];
            rd_data.slot_sel[s]   = m2r_mem[rd_ctx][s];
        end
    end

`ifdef BENES_CTX_PARITY_EN
    logic [STAGE_NUM-1:0] r2m_par [CTX_DEPTH];
    logic [STAGE_NUM-1:0] m2r_par [CTX_DEPTH];

    // Parity bits captured alongside each row write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_net) r2m_par[wr_ctx][wr_stage] <= row_parity(wr_data);
            else         m2r_par[wr_ctx][wr_stage] <= row_parity(wr_data);
        end
    end

    // Any row whose recomputed parity disagrees flags the whole context.
    always_comb begin
        rd_parity_ok = 1'b1;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (row_parity(r2m_mem[rd_ctx][s]) != r2m_par[rd_ctx][s]) rd_parity_ok = 1'b0;
            if (row_parity(m2r_mem[rd_ctx][s]) != m2r_par[rd_ctx][s]) rd_parity_ok = 1'b0;
        end
    end
`else
    assign rd_parity_ok = 1'b1;
`endif

endmodule

// File: rtl/benes_route_sequencer.sv
// Benes route sequencer: context table, IDLE/LOAD/ISSUE burst FSM, launch-to-destination
// delay pipe compensating the 3-register interconnect. Optional BENES_CTX_PARITY_EN
// enables parity checking of the context in LOAD.
module benes_route_sequencer
    import benes_route_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en,
    output logic                  cfg_wr_ready,
    input  logic [CTX_AW-1:0]     cfg_wr_ctx,
    input  logic                  cfg_wr_net,
    input  logic [STAGE_AW-1:0]   cfg_wr_stage,
    input  logic [SWITCH_NUM-1:0] cfg_wr_data,
    input  logic                  cfg_commit,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CTX_AW-1:0]     req_ctx,
    input  logic [LEN_W-1:0]      req_len,
    output sel_t                  o_module_sel,
    output sel_t                  o_slot_sel,
    output logic                  o_src_launch,
    output logic                  o_dst_valid,
    output logic                  o_busy,
    output logic                  o_err
);

    route_seq_state_e    state;
    logic [CTX_AW-1:0]   lat_ctx;
    logic [LEN_W-1:0]    beat_cnt;
    benes_ctx_t          issue_ctx;
    logic [INTC_LAT-1:0] dst_pipe;
    logic                chk_valid;
    benes_ctx_t          rd_data;
    logic                rd_parity_ok;
    logic                req_fire;

    // A request outranks configuration traffic in the same cycle.
    assign req_ready    = (state == IDLE);
    assign cfg_wr_ready = req_ready && !req_valid;
    assign req_fire     = req_valid && req_ready;

    benes_ctx_table u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (cfg_wr_en && cfg_wr_ready),
        .wr_ctx       (cfg_wr_ctx),
        .wr_net       (cfg_wr_net),
        .wr_stage     (cfg_wr_stage),
        .wr_data      (cfg_wr_data),
        .commit       (cfg_commit && cfg_wr_ready),
        .chk_ctx      (req_ctx),
        .chk_valid    (chk_valid),
        .rd_ctx       (lat_ctx),
        .rd_data      (rd_data),
        .rd_parity_ok (rd_parity_ok)
    );

    // Burst FSM with registered launch, error and select outputs.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_ctx      <= '0;
            beat_cnt     <= '0;
            issue_ctx    <= '0;
            o_module_sel <= '0;
            o_slot_sel   <= '0;
            o_src_launch <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_err <= 1'b0;
            // Selects trail launch by one cycle to line up with the data input register.
            if (o_src_launch) begin
                o_module_sel <= issue_ctx.module_sel;
                o_slot_sel   <= issue_ctx.slot_sel;
            end
            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (chk_valid) begin
                            state    <= LOAD;
                            lat_ctx  <= req_ctx;
                            beat_cnt <= req_len;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (rd_parity_ok) begin
                        issue_ctx    <= rd_data;
                        o_src_launch <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (beat_cnt == '0) begin
                        o_src_launch <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Destination-valid delay line matching the interconnect's register depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dst_pipe <= '0;
        else        dst_pipe <= {dst_pipe[INTC_LAT-2:0], o_src_launch};
    end

    assign o_dst_valid = dst_pipe[INTC_LAT-1];
    assign o_busy      = (state != IDLE) || (|dst_pipe);

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Self-checking bench for benes_route_sequencer: table-driven requests, scoreboard of
// expected bursts, and hand-written sequences for arbitration and reset corner cases.
module tb_benes_route_sequencer;
    import benes_route_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_wr_en, cfg_wr_ready, cfg_wr_net, cfg_commit;
    logic [CTX_AW-1:0]     cfg_wr_ctx;
    logic [STAGE_AW-1:0]   cfg_wr_stage;
    logic [SWITCH_NUM-1:0] cfg_wr_data;
    logic                  req_valid, req_ready;
    logic [CTX_AW-1:0]     req_ctx;
    logic [LEN_W-1:0]      req_len;
    sel_t                  o_module_sel, o_slot_sel;
    logic                  o_src_launch, o_dst_valid, o_busy, o_err;

    benes_route_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_ctx(cfg_wr_ctx),
        .cfg_wr_net(cfg_wr_net), .cfg_wr_stage(cfg_wr_stage), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .req_valid(req_valid), .req_ready(req_ready),
        .req_ctx(req_ctx), .req_len(req_len), .o_module_sel(o_module_sel),
        .o_slot_sel(o_slot_sel), .o_src_launch(o_src_launch), .o_dst_valid(o_dst_valid),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference copy of the context table.
    logic [SWITCH_NUM-1:0] m_mod  [CTX_DEPTH][STAGE_NUM];
    logic [SWITCH_NUM-1:0] m_slot [CTX_DEPTH][STAGE_NUM];

    function automatic benes_ctx_t model_ctx(input int ctx);
        benes_ctx_t c;
        for (int s = 0; s < STAGE_NUM; s++) begin
            c.module_sel[s] = m_mod[ctx][s];
            c.slot_sel[s]   = m_slot[ctx][s];
        end
        return c;
    endfunction

    // Scoreboard: expected bursts pushed at request time, launch runs forwarded to the dst check.
    typedef struct { benes_ctx_t exp; int len; int hs; } burst_t;
    typedef struct { int start; int len; } run_t;
    burst_t sb_q[$];
    run_t   dst_q[$];
    burst_t mb;
    run_t   mr;
    bit     l_in = 1'b0, d_in = 1'b0;
    int     l_start, l_len, d_start, d_len;

    always @(negedge clk) begin
        if (!rst_n) begin
            l_in = 1'b0;
            d_in = 1'b0;
            sb_q.delete();
            dst_q.delete();
        end else begin
            if (o_src_launch) begin
                if (!l_in) begin l_in = 1'b1; l_start = cyc; l_len = 0; end
                l_len++;
            end else if (l_in) begin
                l_in = 1'b0;
                check(sb_q.size() != 0, "launch_expected", 0, 1);
                if (sb_q.size() != 0) begin
                    mb = sb_q.pop_front();
                    check(l_start == mb.hs + 2, "launch_offset", l_start - mb.hs, 2);
                    check(l_len == mb.len + 1, "launch_beats", l_len, mb.len + 1);
                    check(o_module_sel == mb.exp.module_sel, "module_sel", o_module_sel, mb.exp.module_sel);
                    check(o_slot_sel == mb.exp.slot_sel, "slot_sel", o_slot_sel, mb.exp.slot_sel);
                end
                dst_q.push_back('{l_start, l_len});
            end
            if (o_dst_valid) begin
                if (!d_in) begin d_in = 1'b1; d_start = cyc; d_len = 0; end
                d_len++;
            end else if (d_in) begin
                d_in = 1'b0;
                check(dst_q.size() != 0, "dst_expected", 0, 1);
                if (dst_q.size() != 0) begin
                    mr = dst_q.pop_front();
                    check(d_start == mr.start + INTC_LAT, "dst_offset", d_start - mr.start, INTC_LAT);
                    check(d_len == mr.len, "dst_beats", d_len, mr.len);
                end
            end
        end
    end

    task automatic write_row(input int ctx, input int net, input int stage, input int data);
        @(negedge clk);
        cfg_wr_en    = 1'b1;
        cfg_wr_ctx   = CTX_AW'(ctx);
        cfg_wr_net   = net[0];
        cfg_wr_stage = STAGE_AW'(stage);
        cfg_wr_data  = SWITCH_NUM'(data);
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
        if (net == 0) m_mod[ctx][stage]  = SWITCH_NUM'(data);
        else          m_slot[ctx][stage] = SWITCH_NUM'(data);
    endtask

    task automatic commit_ctx(input int ctx);
        @(negedge clk);
        cfg_commit = 1'b1;
        cfg_wr_ctx = CTX_AW'(ctx);
        @(posedge clk);
        #1 cfg_commit = 1'b0;
    endtask

    task automatic config_ctx(input int ctx);
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < STAGE_NUM; s++)
                write_row(ctx, n, s, int'($urandom_range(0, (1 << SWITCH_NUM) - 1)));
        commit_ctx(ctx);
    endtask

    task automatic wait_idle(input int budget);
        int bad_rdy = 0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (o_src_launch && (cfg_wr_ready || req_ready)) bad_rdy++;
            if (req_ready && !o_busy) done = 1'b1;
        end
        check(done, "idle_timeout", done, 1);
        check(bad_rdy == 0, "ready_during_issue", bad_rdy, 0);
        check(sb_q.size() == 0 && dst_q.size() == 0, "sb_drain", sb_q.size() + dst_q.size(), 0);
    endtask

    task automatic do_req(input int ctx, input int len, input bit exp_err);
        int hs;
        @(negedge clk);
        hs        = cyc;
        req_valid = 1'b1;
        req_ctx   = CTX_AW'(ctx);
        req_len   = LEN_W'(len);
        #1;
        check(req_ready == 1'b1, "req_ready_idle", req_ready, 1);
        check(cfg_wr_ready == 1'b0, "cfg_blocked_by_req", cfg_wr_ready, 0);
        if (!exp_err) sb_q.push_back('{model_ctx(ctx), len, hs});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1;
        check(o_err == exp_err, "err_t1", o_err, exp_err);
        check(o_src_launch == 1'b0, "no_launch_t1", o_src_launch, 0);
        if (exp_err) begin
            check(req_ready == 1'b1, "ready_after_err", req_ready, 1);
            @(negedge clk);
            #1;
            check(o_err == 1'b0, "err_one_cycle", o_err, 0);
            check(o_src_launch == 1'b0, "no_launch_err", o_src_launch, 0);
        end else begin
            check(req_ready == 1'b0, "busy_in_load", req_ready, 0);
            wait_idle(len + 30);
        end
    endtask

    typedef struct { int ctx; int len; bit cfg; bit poison; bit exp_err; } vec_t;
    vec_t vecs[7];

    initial begin
        int hs;
        bit acc;
        benes_ctx_t old3;

        vecs[0] = '{3,   0, 1'b1, 1'b0, 1'b0};  // single beat, fresh context
        vecs[1] = '{5,   0, 1'b0, 1'b0, 1'b1};  // never committed
        vecs[2] = '{1,   0, 1'b1, 1'b1, 1'b1};  // committed then invalidated by a row write
        vecs[3] = '{7,   2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3,   4, 1'b0, 1'b0, 1'b0};  // reuse of a still-valid context
        vecs[5] = '{0,   1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{15, 255, 1'b1, 1'b0, 1'b0}; // maximum burst

        rst_n = 1'b0;
        cfg_wr_en = 1'b0; cfg_commit = 1'b0; cfg_wr_net = 1'b0;
        cfg_wr_ctx = '0; cfg_wr_stage = '0; cfg_wr_data = '0;
        req_valid = 1'b0; req_ctx = '0; req_len = '0;
        repeat (3) @(negedge clk);
        #1;
        check(o_module_sel == '0 && o_slot_sel == '0, "reset_selects", o_module_sel, 0);
        check(o_src_launch == 1'b0 && o_dst_valid == 1'b0, "reset_launch", o_src_launch, 0);
        check(o_err == 1'b0 && o_busy == 1'b0, "reset_err_busy", o_busy, 0);
        check(req_ready == 1'b1 && cfg_wr_ready == 1'b1, "reset_ready", req_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].cfg) config_ctx(vecs[i].ctx);
            if (vecs[i].poison) write_row(vecs[i].ctx, 1, 0, int'($urandom_range(0, 15)));
            do_req(vecs[i].ctx, vecs[i].len, vecs[i].exp_err);
        end

        // Request and row write in the same idle cycle: request wins, write lands after the burst.
        old3 = model_ctx(3);
        @(negedge clk);
        hs = cyc;
        req_valid = 1'b1; req_ctx = CTX_AW'(3); req_len = LEN_W'(3);
        cfg_wr_en = 1'b1; cfg_wr_ctx = CTX_AW'(3); cfg_wr_net = 1'b0;
        cfg_wr_stage = '0; cfg_wr_data = ~old3.module_sel[0];
        #1;
        check(cfg_wr_ready == 1'b0, "cfg_vs_req_ready", cfg_wr_ready, 0);
        sb_q.push_back('{old3, 3, hs});
        @(posedge clk);
        #1 req_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            #1;
            if (cfg_wr_ready) acc = 1'b1;
        end
        check(acc, "held_write_accepted", acc, 1);
        check(sb_q.size() == 0 && o_src_launch == 1'b0, "write_after_burst", sb_q.size(), 0);
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
        m_mod[3][0] = ~old3.module_sel[0];
        wait_idle(20);
        do_req(3, 0, 1'b1);
        commit_ctx(3);
        do_req(3, 0, 1'b0);

        // Reset at beat 10 of a 20-beat burst.
        config_ctx(2);
        @(negedge clk);
        hs = cyc;
        req_valid = 1'b1; req_ctx = CTX_AW'(2); req_len = LEN_W'(19);
        sb_q.push_back('{model_ctx(2), 19, hs});
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check(o_src_launch == 1'b1 && o_dst_valid == 1'b1, "mid_burst_active", o_src_launch, 1);
        rst_n = 1'b0;
        #1;
        check(o_src_launch == 1'b0 && o_dst_valid == 1'b0, "rst_launch_dst", o_dst_valid, 0);
        check(o_module_sel == '0 && o_slot_sel == '0, "rst_selects", o_module_sel, 0);
        check(o_busy == 1'b0 && req_ready == 1'b1, "rst_busy_ready", o_busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        do_req(2, 0, 1'b1);
        do_req(3, 0, 1'b1);

`ifdef BENES_CTX_PARITY_EN
        begin
            sel_t sel_before;
            config_ctx(6);
            sel_before = o_module_sel;
            force dut.u_table.r2m_mem[6][0][0] = ~m_mod[6][0][0];
            @(negedge clk);
            req_valid = 1'b1; req_ctx = CTX_AW'(6); req_len = '0;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            #1;
            check(o_err == 1'b0, "par_err_t1", o_err, 0);
            @(negedge clk);
            #1;
            check(o_err == 1'b1 && o_src_launch == 1'b0, "par_err_load", o_err, 1);
            release dut.u_table.r2m_mem[6][0][0];
            wait_idle(10);
            check(o_module_sel == sel_before, "par_sel_hold", o_module_sel, sel_before);
        end
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
